// File: rtl/pattern_sequencer.sv
// Pattern sequencer: walks a gate through num_pat input patterns and counts
// mismatches against a fault-free reference. Optional MISR: PATTERN_SEQUENCER_SIG_EN.
module pattern_sequencer #(
   parameter int PAT_W  = 2,
   parameter int CNT_W  = 8,
   parameter int SETTLE = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             abort,
   input  logic [CNT_W-1:0] num_pat,
   output logic [PAT_W-1:0] pattin,
   input  logic             dut_o,
   input  logic             gold_o,
   output logic             busy,
   output logic             done,
   output logic [CNT_W-1:0] fail_cnt,
   output logic [CNT_W-1:0] first_fail
`ifdef PATTERN_SEQUENCER_SIG_EN
   ,
   output logic [15:0]      signature
`endif
);

   localparam logic [2:0] S_IDLE    = 3'd0;
   localparam logic [2:0] S_APPLY   = 3'd1;
   localparam logic [2:0] S_SETTLE  = 3'd2;
   localparam logic [2:0] S_CAPTURE = 3'd3;
   localparam logic [2:0] S_DONE    = 3'd4;

   localparam logic [CNT_W-1:0] ALL_ONES    = {CNT_W{1'b1}};
   localparam int               SETTLE_M1   = (SETTLE > 0) ? SETTLE - 1 : 0;
   localparam logic [3:0]       SETTLE_LD   = SETTLE_M1[3:0];
   localparam logic             SETTLE_ZERO = (SETTLE == 0);

`ifdef PATTERN_SEQUENCER_SIG_EN
   // Galois MISR step for x^16+x^12+x^5+1.
   function automatic logic [15:0] misr_step(input logic [15:0] s, input logic d);
      logic fb;
      fb = s[15] ^ d;
      misr_step = {s[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
   endfunction

   logic [15:0] sig_q, sig_d;
`endif

   logic [2:0]       state_q, state_d;
   logic [CNT_W-1:0] idx_q, idx_d;
   logic [CNT_W-1:0] num_q, num_d;
   logic [3:0]       cnt_q, cnt_d;
   logic [CNT_W-1:0] fail_q, fail_d;
   logic [CNT_W-1:0] first_q, first_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic [CNT_W:0]   idx_nxt_s;
   logic             mism_s;

   // Next-state and datapath update for the run sequencer.
   always_comb begin
      state_d   = state_q;
      idx_d     = idx_q;
      num_d     = num_q;
      cnt_d     = cnt_q;
      fail_d    = fail_q;
      first_d   = first_q;
`ifdef PATTERN_SEQUENCER_SIG_EN
      sig_d     = sig_q;
`endif
      idx_nxt_s = {1'b0, idx_q} + {{CNT_W{1'b0}}, 1'b1};
      mism_s    = dut_o ^ gold_o;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               idx_d   = {CNT_W{1'b0}};
               fail_d  = {CNT_W{1'b0}};
               first_d = ALL_ONES;
               num_d   = num_pat;
`ifdef PATTERN_SEQUENCER_SIG_EN
               sig_d   = 16'h0000;
`endif
               if (num_pat == {CNT_W{1'b0}}) begin
                  state_d = S_DONE;
               end else begin
                  state_d = S_APPLY;
               end
            end else begin
               state_d = S_IDLE;
            end
         end
         S_APPLY: begin
            if (abort) begin
               state_d = S_IDLE;
            end else if (SETTLE_ZERO) begin
               state_d = S_CAPTURE;
            end else begin
               state_d = S_SETTLE;
               cnt_d   = SETTLE_LD;
            end
         end
         S_SETTLE: begin
            if (abort) begin
               state_d = S_IDLE;
            end else if (cnt_q == 4'd0) begin
               state_d = S_CAPTURE;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         S_CAPTURE: begin
            // Abort wins over the capture so counters stay frozen.
            if (abort) begin
               state_d = S_IDLE;
            end else begin
               if (mism_s) begin
                  if (fail_q != ALL_ONES) begin
                     fail_d = fail_q + {{(CNT_W-1){1'b0}}, 1'b1};
                  end else begin
                     fail_d = fail_q;
                  end
                  if (first_q == ALL_ONES) begin
                     first_d = idx_q;
                  end else begin
                     first_d = first_q;
                  end
               end else begin
                  fail_d = fail_q;
               end
`ifdef PATTERN_SEQUENCER_SIG_EN
               sig_d = misr_step(sig_q, dut_o);
`endif
               if (idx_nxt_s < {1'b0, num_q}) begin
                  idx_d   = idx_nxt_s[CNT_W-1:0];
                  state_d = S_APPLY;
               end else begin
                  state_d = S_DONE;
               end
            end
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
      busy_d = (state_d != S_IDLE);
      done_d = (state_d == S_DONE);
   end

   // State and output registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         idx_q   <= {CNT_W{1'b0}};
         num_q   <= {CNT_W{1'b0}};
         cnt_q   <= 4'd0;
         fail_q  <= {CNT_W{1'b0}};
         first_q <= ALL_ONES;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
`ifdef PATTERN_SEQUENCER_SIG_EN
         sig_q   <= 16'h0000;
`endif
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         num_q   <= num_d;
         cnt_q   <= cnt_d;
         fail_q  <= fail_d;
         first_q <= first_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
`ifdef PATTERN_SEQUENCER_SIG_EN
         sig_q   <= sig_d;
`endif
      end
   end

   assign pattin     = idx_q[PAT_W-1:0];
   assign busy       = busy_q;
   assign done       = done_q;
   assign fail_cnt   = fail_q;
   assign first_fail = first_q;
`ifdef PATTERN_SEQUENCER_SIG_EN
   assign signature  = sig_q;
`endif

endmodule
